// File: rtl/link_arb_pkg.sv
// Shared constants and state encoding for the root-hub leaf link scheduler.
package link_arb_pkg;
    localparam int         LINK_DATA_W   = 64;
    localparam int         LINK_DEST_MSB = 63;
    localparam logic [7:0] LINK_BCAST_ID = 8'hFF;

    typedef enum logic {IDLE, LOCKED} state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 1,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);
    always_comb begin
        int k;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        k       = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr) + off;
            if (k >= N) k = k - N;
            if (!gnt_vld && req[k]) begin
                gnt_vld   = 1'b1;
                gnt_oh[k] = 1'b1;
                gnt_idx   = IW'(k);
            end
        end
    end
endmodule

// File: rtl/leaf_link_arbiter.sv
// Root-hub link scheduler: round-robin packet-atomic upstream merge of leaf channels,
// destination-steered (or broadcast) downstream fan-out to the leaves.
module leaf_link_arbiter
    import link_arb_pkg::*;
#(
    parameter int         NUM_LEAVES = 1,
    parameter int         DATA_WIDTH = LINK_DATA_W,
    parameter int         DEST_MSB   = LINK_DEST_MSB,
    parameter logic [7:0] BCAST_ID   = LINK_BCAST_ID
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH*NUM_LEAVES-1:0] leaf_rx_data,
    input  logic [NUM_LEAVES-1:0]            leaf_rx_valid,
    input  logic [NUM_LEAVES-1:0]            leaf_rx_last,
    output logic [NUM_LEAVES-1:0]            leaf_rx_ready,
    output logic [DATA_WIDTH-1:0]            up_tx_data,
    output logic                             up_tx_valid,
    output logic                             up_tx_last,
    output logic [7:0]                       up_tx_src,
    input  logic                             up_tx_ready,
    input  logic [DATA_WIDTH-1:0]            root_rx_data,
    input  logic                             root_rx_valid,
    output logic                             root_rx_ready,
    output logic [DATA_WIDTH*NUM_LEAVES-1:0] leaf_tx_data,
    output logic [NUM_LEAVES-1:0]            leaf_tx_valid,
    input  logic [NUM_LEAVES-1:0]            leaf_tx_ready,
    output logic                             bad_dest
);
    localparam int IW = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;

    state_e                  state_q, state_d;
    logic [IW-1:0]           lock_q, lock_d, rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   up_data_q, up_data_d;
    logic                    up_valid_q, up_valid_d, up_last_q, up_last_d;
    logic [7:0]              up_src_q, up_src_d;
    logic [NUM_LEAVES-1:0]   sent_q, sent_d;
    logic                    bad_dest_q, bad_dest_d;

    logic [NUM_LEAVES-1:0]   arb_req, gnt_oh, lock_oh, target;
    logic [IW-1:0]           arb_ptr, gnt_idx, gnt_next;
    logic                    gnt_vld, gnt_last, slot_free, load, root_hs;
    logic [7:0]              dest;

    rr_arbiter #(.N(NUM_LEAVES), .IW(IW)) u_rr (
        .req     (arb_req),
        .ptr     (arb_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // While a packet is in flight the arbiter only sees the locked leaf.
    always_comb begin
        lock_oh = NUM_LEAVES'(1) << lock_q;
        arb_req = leaf_rx_valid;
        arb_ptr = rr_ptr_q;
        if (state_q == LOCKED) begin
            arb_req = leaf_rx_valid & lock_oh;
            arb_ptr = lock_q;
        end
        slot_free     = !up_valid_q || up_tx_ready;
        load          = gnt_vld && slot_free;
        leaf_rx_ready = (slot_free && reset) ? gnt_oh : '0;
        gnt_last      = leaf_rx_last[gnt_idx];
        gnt_next      = (gnt_idx == IW'(NUM_LEAVES - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        rr_ptr_d   = rr_ptr_q;
        up_data_d  = up_data_q;
        up_valid_d = up_valid_q;
        up_last_d  = up_last_q;
        up_src_d   = up_src_q;
        if (load) begin
            up_data_d  = leaf_rx_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            up_valid_d = 1'b1;
            up_last_d  = gnt_last;
            up_src_d   = 8'(gnt_idx) + 8'd1;
            case (state_q)
                IDLE: begin
                    rr_ptr_d = gnt_next;
                    if (!gnt_last) begin
                        state_d = LOCKED;
                        lock_d  = gnt_idx;
                    end
                end
                LOCKED: if (gnt_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (up_tx_ready) begin
            up_valid_d = 1'b0;
            up_last_d  = 1'b0;
        end
    end

    assign up_tx_data  = up_data_q;
    assign up_tx_valid = up_valid_q;
    assign up_tx_last  = up_last_q;
    assign up_tx_src   = up_src_q;

    assign dest = root_rx_data[DEST_MSB -: 8];

    for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
        assign target[i] = (dest == BCAST_ID) || (dest == 8'(i + 1));
        assign leaf_tx_data[i*DATA_WIDTH +: DATA_WIDTH] = root_rx_data;
    end

    // sent remembers which broadcast targets already took the current word.
    always_comb begin
        leaf_tx_valid = {NUM_LEAVES{root_rx_valid}} & target & ~sent_q;
        root_rx_ready = &(~target | sent_q | leaf_tx_ready);
        root_hs       = root_rx_valid && root_rx_ready;
        sent_d        = root_hs ? '0 : (sent_q | (leaf_tx_valid & leaf_tx_ready));
        bad_dest_d    = root_hs && (target == '0);
    end

    assign bad_dest = bad_dest_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lock_q     <= '0;
            rr_ptr_q   <= '0;
            up_data_q  <= '0;
            up_valid_q <= 1'b0;
            up_last_q  <= 1'b0;
            up_src_q   <= '0;
            sent_q     <= '0;
            bad_dest_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            rr_ptr_q   <= rr_ptr_d;
            up_data_q  <= up_data_d;
            up_valid_q <= up_valid_d;
            up_last_q  <= up_last_d;
            up_src_q   <= up_src_d;
            sent_q     <= sent_d;
            bad_dest_q <= bad_dest_d;
        end
    end
endmodule
